// File: rtl/aes_shift_rows_pipe_pkg.sv
// aes_shift_rows_pipe_pkg: state and operation types plus the ShiftRows/InvShiftRows byte permutation
package aes_shift_rows_pipe_pkg;

    typedef enum logic {SR_FWD = 1'b0, SR_INV = 1'b1} sr_op_e;

    typedef logic [3:0][3:0][7:0] aes_state_t;

    // Column indices wrap naturally in 2 bits, giving the mod-4 rotation for free
    function automatic aes_state_t aes_shift_rows_perm(aes_state_t s, sr_op_e op);
        aes_state_t p;
        logic [1:0] col;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                col = (op == SR_FWD) ? 2'(c + r) : 2'(c - r);
                p[r][c] = s[r][col];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_shift_rows_stage.sv
// aes_shift_rows_stage: one elastic register stage holding a valid bit and NumShares states, with clear-to-prd
module aes_shift_rows_stage
    import aes_shift_rows_pipe_pkg::*;
#(
    parameter int NumShares = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic [127:0]               prd_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  aes_state_t [NumShares-1:0] data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output aes_state_t [NumShares-1:0] data_o
);

    logic                       valid_q;
    aes_state_t [NumShares-1:0] data_q;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign data_o      = data_q;

    // Each share gets its own copy of prd_i so no path ever mixes shares
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            for (int s = 0; s < NumShares; s++) data_q[s] <= prd_i;
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            if (in_valid_i) data_q <= data_i;
        end
    end

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// aes_shift_rows_pipe: share-wise ShiftRows/InvShiftRows followed by a NumStages-deep elastic register pipeline
module aes_shift_rows_pipe
    import aes_shift_rows_pipe_pkg::*;
#(
    parameter int NumShares = 3,
    parameter int NumStages = 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  clear_i,
    input  logic [127:0]                          prd_i,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    input  logic                                  op_i,
    input  logic [NumShares-1:0][3:0][3:0][7:0]   data_i,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic [NumShares-1:0][3:0][3:0][7:0]   data_o,
    output logic                                  busy_o
);

    aes_state_t [NumShares-1:0] perm;

    always_comb begin
        for (int s = 0; s < NumShares; s++) perm[s] = aes_shift_rows_perm(data_i[s], sr_op_e'(op_i));
    end

    if (NumStages == 0) begin : g_comb
        assign data_o      = perm;
        assign out_valid_o = in_valid_i && !clear_i;
        assign in_ready_o  = out_ready_i && !clear_i;
        assign busy_o      = 1'b0;
    end else begin : g_pipe
        logic                       vld [NumStages+1];
        logic                       rdy [NumStages+1];
        aes_state_t [NumShares-1:0] dat [NumStages+1];
        logic [NumStages-1:0]       stage_valid;

        // A clear blocks acceptance so the flushed pipeline stays empty
        assign vld[0]         = in_valid_i && !clear_i;
        assign dat[0]         = perm;
        assign rdy[NumStages] = out_ready_i;

        for (genvar i = 0; i < NumStages; i++) begin : g_stage
            aes_shift_rows_stage #(.NumShares(NumShares)) u_stage (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .clear_i    (clear_i),
                .prd_i      (prd_i),
                .in_valid_i (vld[i]),
                .in_ready_o (rdy[i]),
                .data_i     (dat[i]),
                .out_valid_o(vld[i+1]),
                .out_ready_i(rdy[i+1]),
                .data_o     (dat[i+1])
            );
            assign stage_valid[i] = vld[i+1];
        end

        assign in_ready_o  = rdy[0] && !clear_i;
        assign out_valid_o = vld[NumStages];
        assign data_o      = dat[NumStages];
        assign busy_o      = |stage_valid;
    end

endmodule

// File: doc/aes_shift_rows_pipe.md
Name: aes_shift_rows_pipe

Overview:
Parametrised, multi-share ShiftRows / InvShiftRows stage for the masked AES datapath. It applies the row rotation to each share independently, and never combines shares. Results pass through a configurable elastic register pipeline with a valid/ready handshake. A clear input flushes in-flight data and overwrites the share registers with pseudo-random data.

Parameters:
NumShares, 3, number of Boolean shares per state (3 = second-order masking); legal range 1..4.
NumStages, 1, number of register stages, equal to latency in cycles; 0 = combinational pass-through.

Ports:
clk_i  input  1  clock
rst_i  input  1  reset; asynchronous, active-high
clear_i  input  1  flush pipeline and overwrite share registers with prd_i
prd_i  input  128  pseudo-random fill data, interpreted as [3:0][3:0][7:0]
in_valid_i  input  1  input state valid
in_ready_o  output  1  block accepts input this cycle
op_i  input  1  sr_op_e: 0 = SR_FWD, 1 = SR_INV; sampled with data_i
data_i  input  NumShares*128  [NumShares-1:0][3:0][3:0][7:0] as [share][row][col][byte]
out_valid_o  output  1  output state valid
out_ready_i  input  1  downstream accepts output
data_o  output  NumShares*128  permuted shares, same layout as data_i
busy_o  output  1  at least one stage holds valid data

Behaviour:
- Permutation, per share s, row r, column c:
  - SR_FWD: out[s][r][c] = in[s][r][(c+r) mod 4]
  - SR_INV: out[s][r][c] = in[s][r][(c-r) mod 4]
  - Row 0 is unchanged. All 8 bits of a byte move together.
- The permutation is applied combinationally before stage 0. Stages hold only the permuted shares and a valid bit.
- No logic may combine bytes of different shares, including in the clear and mux paths.
- Handshake:
  - ready[NumStages] = out_ready_i.
  - For each stage i: ready[i] = !valid[i] || ready[i+1].
  - in_ready_o = ready[0] && !clear_i.
  - A transfer occurs when valid && ready are both high.
  - Stage i loads from stage i-1 (stage 0 loads from the input) when ready[i] is high. Its valid bit takes the upstream valid at that edge.
  - Data registers load only on an accepted transfer, so there is no toggling on bubbles.
  - Upstream must hold data_i and op_i stable while in_valid_i && !in_ready_o.
- Latency and throughput:
  - A state accepted at edge t appears on data_o with out_valid_o = 1 during the cycle after edge t+NumStages-1, i.e. NumStages cycles later.
  - Sustained throughput is 1 state per cycle when out_ready_i is held high.
  - Order is preserved.
  - While stalled, data_o and out_valid_o hold stable.
- NumStages = 0: data_o is the combinational permutation of data_i; out_valid_o = in_valid_i && !clear_i; in_ready_o = out_ready_i && !clear_i; busy_o = 0.
- clear_i (synchronous, single cycle or held):
  - At the next edge all valid bits go to 0.
  - Every share register of every stage loads prd_i, with the same value written to each share.
  - Clear has priority over simultaneous input acceptance or advancement; an input presented during clear is not accepted.
- Reset (rst_i high, asynchronous): all valid bits go to 0 and all data registers go to 0 immediately, mid-transfer included. out_valid_o = 0, busy_o = 0, data_o = 0. in_ready_o = 1 after deassertion.
- busy_o = OR of all stage valid bits.

Decomposition:
- aes_pkg additions: typedef enum logic {SR_FWD, SR_INV} sr_op_e; typedef logic [3:0][3:0][7:0] aes_state_t; function aes_shift_rows_perm(aes_state_t, sr_op_e).
- One sub-module: aes_shift_rows_stage, a single elastic register stage holding valid plus NumShares states, with a clear/prd load path.
- The top-level generates NumStages instances of aes_shift_rows_stage.

Test Plan:
1. NumShares=1, NumStages=1. Drive share 0 with byte[r][c] = 8'h{r,c}, SR_FWD -> one cycle later data_o[0][1][0]=8'h11, [1][3]=8'h10, [2][0]=8'h22, [3][0]=8'h33; row 0 unchanged.
2. Same input with SR_INV -> data_o[0][1][0]=8'h13, [2][1]=8'h23, [3][0]=8'h31. Also feed the SR_FWD output back as SR_INV input -> original state is recovered.
3. NumShares=3. Share1=R1 and share2=R2 are random; share0 = S^R1^R2 -> each output share equals the permutation of its own input share, and the XOR of the outputs equals the permutation of S.
4. NumStages=2. out_ready_i held low, offer 4 states back-to-back -> exactly 2 accepted, then in_ready_o=0. Raise out_ready_i -> states emerge in order, one per cycle. No loss or duplication.
5. NumStages=2. Two states in flight, pulse clear_i with prd_i=128'hA5..A5 while in_valid_i=1 -> next cycle out_valid_o=0, busy_o=0, all data_o shares = 128'hA5..A5. The input offered during clear is not accepted.
6. Assert rst_i asynchronously mid-stream between clock edges -> outputs go to 0 immediately. After release, 8 back-to-back states complete with exactly NumStages latency.
